qix_video_scanout: RTL and testbench

- Raster timing generator and VRAM fetch pipeline feeding the palette stage's pixel_index input.
- Counts pixels and lines on a pixel clock enable, and issues one VRAM byte read per active pixel.
- Delays sync and blank so they stay aligned with the palette's registered RGB outputs.
- Exposes the current scanline for the video CPU readback at $9800, plus a vblank-start pulse.

---
 rtl/qix_video_pkg.sv | 30 +++
 rtl/qix_video_scanout_if.sv | 11 +
 rtl/qix_raster_counter.sv | 65 ++++++
 rtl/qix_video_scanout.sv | 114 +++++++++++
 tb/tb_qix_video_scanout.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/qix_video_pkg.sv
// Shared raster timing defaults and the sync/blank delay-pipeline element for the Qix video scanout.
package qix_video_pkg;

    localparam int unsigned DEF_H_ACTIVE     = 256;
    localparam int unsigned DEF_H_TOTAL      = 320;
    localparam int unsigned DEF_H_SYNC_START = 272;
    localparam int unsigned DEF_H_SYNC_LEN   = 24;
    localparam int unsigned DEF_V_ACTIVE     = 256;
    localparam int unsigned DEF_V_TOTAL      = 264;
    localparam int unsigned DEF_V_SYNC_START = 258;
    localparam int unsigned DEF_V_SYNC_LEN   = 3;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic active;
    } raster_flags_t;

    // Cocktail flip mirrors both axes by inverting the line and pixel fields.
    function automatic logic [15:0] vram_address(input logic [7:0] line,
                                                 input logic [7:0] pixel,
                                                 input logic       flip);
        logic [15:0] addr;
        addr = {line, pixel};
        return flip ? ~addr : addr;
    endfunction

endpackage

// File: rtl/qix_video_scanout_if.sv
// VRAM read port between the scanout (master) and the VRAM/arbiter (slave).
interface qix_video_scanout_if;

    logic [15:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_din;

    modport master (output vram_addr, output vram_rd, input vram_din);
    modport slave  (input vram_addr, input vram_rd, output vram_din);

endinterface

// File: rtl/qix_raster_counter.sv
// Pixel/line counters with wrap, raw sync/blank flags, scanline readback and vblank-start pulse.
module qix_raster_counter
    import qix_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN,
    localparam int unsigned H_W = $clog2(H_TOTAL),
    localparam int unsigned V_W = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce_pix,
    output logic [H_W-1:0] hcount,
    output logic [V_W-1:0] vcount,
    output logic [7:0]     scanline,
    output logic           vblank_start,
    output raster_flags_t  flags_c
);

    logic h_wrap_c;
    logic v_wrap_c;

    assign h_wrap_c = (hcount == H_W'(H_TOTAL - 1));
    assign v_wrap_c = (vcount == V_W'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount       <= '0;
            vcount       <= '0;
            scanline     <= '0;
            vblank_start <= 1'b0;
        end else begin
            vblank_start <= 1'b0;
            if (ce_pix) begin
                if (h_wrap_c) begin
                    hcount       <= '0;
                    vcount       <= v_wrap_c ? '0 : vcount + V_W'(1);
                    scanline     <= v_wrap_c ? 8'h00 : 8'(vcount + V_W'(1));
                    vblank_start <= (vcount == V_W'(V_ACTIVE - 1));
                end else begin
                    hcount <= hcount + H_W'(1);
                end
            end
        end
    end

    // Compared at 32 bits so sync end points equal to the total cannot overflow.
    always_comb begin
        flags_c        = '0;
        flags_c.hblank = (32'(hcount) >= H_ACTIVE);
        flags_c.vblank = (32'(vcount) >= V_ACTIVE);
        flags_c.hsync  = (32'(hcount) >= H_SYNC_START) &&
                         (32'(hcount) <  H_SYNC_START + H_SYNC_LEN);
        flags_c.vsync  = (32'(vcount) >= V_SYNC_START) &&
                         (32'(vcount) <  V_SYNC_START + V_SYNC_LEN);
        flags_c.active = !flags_c.hblank && !flags_c.vblank;
    end

endmodule

// File: rtl/qix_video_scanout.sv
// Raster timing, VRAM fetch pipeline and sync/blank alignment for the palette stage.
// Optional cocktail flip addressing is built when QIX_SCANOUT_FLIP_EN is defined.
module qix_video_scanout
    import qix_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN,
    localparam int unsigned H_W = $clog2(H_TOTAL),
    localparam int unsigned V_W = $clog2(V_TOTAL)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ce_pix,
    input  logic                       flip,
    qix_video_scanout_if.master        vram,
    output logic [7:0]                 pixel_index,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       hblank,
    output logic                       vblank,
    output logic [7:0]                 scanline,
    output logic                       vblank_start
);

    logic [H_W-1:0] hcount;
    logic [V_W-1:0] vcount;
    raster_flags_t  flags_c;
    raster_flags_t  flags_a;
    raster_flags_t  flags_b;
    logic           flip_eff_c;

    qix_raster_counter #(
        .H_ACTIVE     (H_ACTIVE),
        .H_TOTAL      (H_TOTAL),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_LEN   (H_SYNC_LEN),
        .V_ACTIVE     (V_ACTIVE),
        .V_TOTAL      (V_TOTAL),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_LEN   (V_SYNC_LEN)
    ) u_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce_pix       (ce_pix),
        .hcount       (hcount),
        .vcount       (vcount),
        .scanline     (scanline),
        .vblank_start (vblank_start),
        .flags_c      (flags_c)
    );

`ifdef QIX_SCANOUT_FLIP_EN
    logic flip_latched;
    logic frame_start_c;

    assign frame_start_c = (hcount == '0) && (vcount == '0);
    // The (0,0) fetch already uses the newly sampled flip so the whole frame is consistent.
    assign flip_eff_c    = frame_start_c ? flip : flip_latched;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flip_latched <= 1'b0;
        end else if (ce_pix && frame_start_c) begin
            flip_latched <= flip;
        end
    end
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign flip_eff_c  = 1'b0;
`endif

    // Stage A issues the read, stage B captures the byte one ce_pix later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram.vram_addr <= '0;
            vram.vram_rd   <= 1'b0;
            flags_a        <= '0;
            pixel_index    <= '0;
            flags_b        <= '0;
        end else if (ce_pix) begin
            vram.vram_addr <= vram_address(8'(vcount), 8'(hcount), flip_eff_c);
            vram.vram_rd   <= flags_c.active;
            flags_a        <= flags_c;
            pixel_index    <= flags_a.active ? vram.vram_din : 8'h00;
            flags_b        <= flags_a;
        end
    end

    // Extra clk stage matches the palette lookup latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            hblank <= 1'b0;
            vblank <= 1'b0;
        end else begin
            hsync  <= flags_b.hsync;
            vsync  <= flags_b.vsync;
            hblank <= flags_b.hblank;
            vblank <= flags_b.vblank;
        end
    end

    logic unused_active;
    assign unused_active = flags_b.active;

endmodule

// File: tb/tb_qix_video_scanout.sv
// Directed scoreboard bench for qix_video_scanout on a reduced raster, with a 1-clk palette model.
module tb_qix_video_scanout;

    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int HSS = 18;
    localparam int HSL = 3;
    localparam int VA  = 8;
    localparam int VT  = 12;
    localparam int VSS = 9;
    localparam int VSL = 2;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] pix;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
    } exp_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix  = 1'b0;
    logic       flip    = 1'b0;
    logic [7:0] pixel_index;
    logic       hsync, vsync, hblank, vblank;
    logic [7:0] scanline;
    logic       vblank_start;
    logic [7:0] pal_q;

    qix_video_scanout_if vif ();

    qix_video_scanout #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce_pix       (ce_pix),
        .flip         (flip),
        .vram         (vif),
        .pixel_index  (pixel_index),
        .hsync        (hsync),
        .vsync        (vsync),
        .hblank       (hblank),
        .vblank       (vblank),
        .scanline     (scanline),
        .vblank_start (vblank_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) vif.vram_din <= vif.vram_addr[7:0] ^ vif.vram_addr[15:8];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pal_q <= 8'h00;
        else          pal_q <= pixel_index;
    end

    exp_t        sb[$];
    exp_t        last_exp;
    logic [15:0] last_addr;
    logic        last_rd;
    int          mh, mv, ce_cnt, n_tests, n_fail;
    int          vbs_count, vbs_last;
    logic        m_flip;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_active(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic exp_t model_exp(input int h, input int v);
        exp_t e;
        e.h   = h;
        e.v   = v;
        e.pix = is_active(h, v) ? (8'(h) ^ 8'(v)) : 8'h00;
        e.hs  = (h >= HSS) && (h < HSS + HSL);
        e.vs  = (v >= VSS) && (v < VSS + VSL);
        e.hb  = (h >= HA);
        e.vb  = (v >= VA);
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.h = -1; e.v = -1; e.pix = 8'h00;
        e.hs = 1'b0; e.vs = 1'b0; e.hb = 1'b0; e.vb = 1'b0;
        return e;
    endfunction

    task automatic check_outputs(input exp_t e);
        chk("pixel_rgb", 32'(pal_q),  32'(e.pix));
        chk("hsync",     32'(hsync),  32'(e.hs));
        chk("vsync",     32'(vsync),  32'(e.vs));
        chk("hblank",    32'(hblank), 32'(e.hb));
        chk("vblank",    32'(vblank), 32'(e.vb));
    endtask

    // One pixel: ce_pix high for a single clk, then three idle clks.
    task automatic ce_step();
        logic        feff;
        logic [15:0] ea;
        logic        last_line;
        exp_t        e;
        @(negedge clk);
        ce_pix = 1'b1;
`ifdef QIX_SCANOUT_FLIP_EN
        feff = (mh == 0 && mv == 0) ? flip : m_flip;
        if (mh == 0 && mv == 0) m_flip = flip;
`else
        feff = 1'b0;
`endif
        sb.push_back(model_exp(mh, mv));
        ea = {8'(mv), 8'(mh)};
        if (feff) ea = ~ea;
        @(posedge clk);
        #1;
        chk("vram_rd", 32'(vif.vram_rd), 32'(is_active(mh, mv)));
        if (is_active(mh, mv)) chk("vram_addr", 32'(vif.vram_addr), 32'(ea));
`ifdef QIX_SCANOUT_FLIP_EN
        if (mh == 0 && mv == 0 && feff)   chk("flip_addr_0_0", 32'(vif.vram_addr), 32'h0000_FFFF);
        if (mh == 1 && mv == 2 && m_flip) chk("flip_addr_1_2", 32'(vif.vram_addr), 32'h0000_FDFE);
`endif
        last_line = (mh == HT - 1) && (mv == VA - 1);
        chk("vblank_start", 32'(vblank_start), 32'(last_line));
        last_addr = ea;
        last_rd   = is_active(mh, mv);
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end
        ce_cnt++;
        if (vblank_start) begin
            if (vbs_last >= 0) chk("frame_len", 32'(ce_cnt - vbs_last), 32'(HT * VT));
            vbs_last = ce_cnt;
            vbs_count++;
        end
        chk("scanline", 32'(scanline), 32'(8'(mv)));
        @(negedge clk);
        ce_pix = 1'b0;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            last_exp = e;
            check_outputs(e);
            if (e.h == 5 && e.v == 3) begin
                chk("pix_5_3",    32'(pal_q), 32'h06);
                chk("blank_5_3",  32'({hblank, vblank}), 32'd0);
            end
        end
        chk("vblank_start_clr", 32'(vblank_start), 32'd0);
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"},     32'(vif.vram_addr),  32'd0);
        chk({tag, "_rd"},       32'(vif.vram_rd),    32'd0);
        chk({tag, "_pix"},      32'(pixel_index),    32'd0);
        chk({tag, "_syncs"},    32'({hsync, vsync}), 32'd0);
        chk({tag, "_blanks"},   32'({hblank, vblank}), 32'd0);
        chk({tag, "_scanline"}, 32'(scanline),       32'd0);
        chk({tag, "_vbstart"},  32'(vblank_start),   32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        mh = 0; mv = 0; m_flip = 1'b0;
        sb.delete();
        sb.push_back(zero_exp());
    endtask

    initial begin
        n_tests = 0; n_fail = 0; ce_cnt = 0;
        vbs_count = 0; vbs_last = -1;
        mh = 0; mv = 0; m_flip = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        release_reset();

        repeat (100) ce_step();

        // Stall: everything must hold at the last pixel.
        repeat (100) @(posedge clk);
        #1;
        check_outputs(last_exp);
        chk("stall_addr",     32'(vif.vram_addr), 32'(last_addr));
        chk("stall_rd",       32'(vif.vram_rd),   32'(last_rd));
        chk("stall_scanline", 32'(scanline),      32'(8'(mv)));

        while (ce_cnt < HT * VT + 100) ce_step();
        flip = 1'b1;
        while (ce_cnt < 2 * HT * VT + 2 * HT + 5) ce_step();
        flip = 1'b0;
        repeat (30) ce_step();

        // Mid-line asynchronous reset.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(posedge clk);
        release_reset();
        repeat (40) ce_step();

        chk("vblank_start_count", 32'(vbs_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
